wb_arbiter2: RTL
================

WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL expose parameter TIMEOUT, default 16, meaning cycles a granted strobe may wait for s_ack_i before abort (range 2..255).
REQ-002 SHALL expose port clk_i  input  1  system clock; the block has one clock, and all state changes on its rising edge.
REQ-003 SHALL expose port rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL expose ports m0_adr_i, m1_adr_i  input  32  master address.
REQ-005 SHALL expose ports m0_dat_i, m1_dat_i  input  32  master write data.
REQ-006 SHALL expose ports m0_dat_o, m1_dat_o  output  32  read data returned to the master.
REQ-007 SHALL expose ports m0_sel_i, m1_sel_i  input  4  master byte selects.
REQ-008 SHALL expose ports m0_we_i, m1_we_i, m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i  input  1  master controls.
REQ-009 SHALL expose ports m0_ack_o, m1_ack_o, m0_err_o, m1_err_o  output  1  master terminations.
REQ-010 SHALL expose ports s_adr_o (32), s_dat_o (32), s_sel_o (4), s_we_o, s_cyc_o, s_stb_o (1)  output  shared slave bus.
REQ-011 SHALL expose ports s_dat_i  input  32 and s_ack_i  input  1  slave responses.

Function
REQ-012 SHALL implement a registered FSM with states IDLE, GNT0 and GNT1, plus a 1-bit last_r holding the last granted master.
REQ-013 In IDLE with exactly one mi_cyc_i high, the FSM SHALL move to GNTi on the next edge.
REQ-014 In IDLE with both cyc high, the FSM SHALL grant the master not equal to last_r (round-robin); last_r SHALL update on every grant.
REQ-015 In GNTi, the grant SHALL hold while mi_cyc_i is high; when mi_cyc_i is low, the FSM SHALL return to IDLE (one idle cycle between grants, no back-to-back handover).
REQ-016 In GNTi, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o and s_stb_o SHALL combinationally equal master i's inputs; in IDLE, s_cyc_o and s_stb_o SHALL be 0 and the other s_* outputs 0.
REQ-017 mi_ack_o SHALL equal s_ack_i only while in GNTi; the non-granted master's ack_o and err_o SHALL be 0.
REQ-018 mi_dat_o SHALL equal s_dat_i while in GNTi, and 0 otherwise.
REQ-019 Grant latency SHALL be one cycle from cyc assertion in IDLE; the slave sees the request in the first GNTi cycle.
REQ-020 If a master drops cyc while the slave is mid-transfer, the FSM SHALL return to IDLE and SHALL discard any later s_ack_i.
REQ-021 A simultaneous cyc drop by the granted master and a request from the other master SHALL yield IDLE, then a grant to the other master.

Reset
REQ-022 When rst_n_i is low, the FSM SHALL asynchronously go to IDLE, last_r SHALL be 1 (so master 0 wins first contention), the timeout counter SHALL be 0, and all outputs SHALL be 0.
REQ-023 A reset asserted mid-transfer SHALL abort the transfer without asserting any ack_o or err_o.

Configuration
REQ-024 With macro WB_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL:
- clear on entering GNTi and on each s_ack_i;
- increment each cycle in GNTi with stb high and s_ack_i low;
- on reaching TIMEOUT, pulse mi_err_o for one cycle, force IDLE, and suppress s_cyc_o/s_stb_o in that cycle.
REQ-025 Without WB_ARB_TIMEOUT_EN, no counter SHALL be instantiated, m0_err_o and m1_err_o SHALL be tied to 0, and grants SHALL be held indefinitely.

Verification
REQ-026 Bench SHALL cover a single master: m0 writes 0x000000A5 to 0x00000400 -> s_cyc_o rises one cycle after m0_cyc_i, s_dat_o=0x000000A5, and m0_ack_o mirrors s_ack_i.
REQ-027 Bench SHALL cover contention: m0 and m1 assert cyc in the same cycle after reset -> m0 is granted; after m0 releases, one IDLE cycle, then m1 is granted.
REQ-028 Bench SHALL cover fairness: both masters request continuously for 4 transfers -> grant order 0,1,0,1.
REQ-029 Bench SHALL cover read isolation: m1 reads while the slave returns 0x12345678 -> m1_dat_o=0x12345678, and m0_dat_o=0 with m0_ack_o=0.
REQ-030 Bench SHALL cover timeout (macro on, TIMEOUT=16): the slave never acks -> m0_err_o pulses on the 16th stalled cycle, then the FSM is IDLE; with the macro off, the grant holds for more than 100 cycles.
REQ-031 Bench SHALL cover reset: rst_n_i is pulled low during GNT1 -> all outputs are 0 immediately, with no ack or err.

Source files
------------

// File: rtl/wb_arbiter2.sv
// ---------------------------------------------------------------------------
// wb_arbiter2
//
// Two-master, one-slave Wishbone arbiter. One master at a time owns the
// shared slave bus. Contention is resolved round-robin against the last
// granted master. A grant holds while the owner keeps cyc high. There is
// always one idle cycle between two grants.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to add a stall watchdog. A
// granted strobe that waits TIMEOUT cycles without s_ack_i is aborted: the
// owner sees a one-cycle err pulse, and the arbiter drops back to IDLE.
// Without the macro, err outputs are tied low and grants never expire.
//
// Parameters
//   TIMEOUT     stalled cycles before abort (2..255, watchdog build only)
//
// Ports
//   clk_i       system clock, rising edge
//   rst_n_i     asynchronous active-low reset
//   mN_adr_i    master N address          mN_dat_i  master N write data
//   mN_sel_i    master N byte selects     mN_we_i   master N write enable
//   mN_cyc_i    master N bus cycle        mN_stb_i  master N strobe
//   mN_dat_o    read data to master N     mN_ack_o  ack to master N
//   mN_err_o    watchdog abort to master N
//   s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o   shared slave bus
//   s_dat_i     slave read data           s_ack_i   slave acknowledge
// ---------------------------------------------------------------------------
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_r, last_d;
    logic   timeout_hit;

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog: counts stalled strobe cycles of the current owner.
    // The abort fires in the cycle where the count would reach TIMEOUT.
    // That cycle is the TIMEOUT-th stalled cycle.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic       cur_cyc;
    logic       cur_stb;

    assign cur_cyc = (state_q == GNT0) ? m0_cyc_i :
                     (state_q == GNT1) ? m1_cyc_i : 1'b0;
    assign cur_stb = (state_q == GNT0) ? m0_stb_i :
                     (state_q == GNT1) ? m1_stb_i : 1'b0;

    assign timeout_hit = cur_cyc && cur_stb && !s_ack_i && (cnt_q == LIMIT);

    // Cleared in IDLE, which precedes every grant. Also cleared on ack,
    // on release and on abort, so each new strobe starts from zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= 8'd0;
        end else if (state_q == IDLE || !cur_cyc || s_ack_i || timeout_hit) begin
            cnt_q <= 8'd0;
        end else if (cur_stb) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            last_r  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_r  <= last_d;
        end
    end

    // Grant decisions happen only from IDLE. A released or aborted grant
    // always passes through IDLE, so there is never a direct handover.
    always_comb begin
        state_d = state_q;
        last_d  = last_r;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (last_r) begin
                        state_d = GNT0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = GNT1;
                        last_d  = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i || timeout_hit) state_d = IDLE;
            end
            GNT1: begin
                if (!m1_cyc_i || timeout_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Combinational bus steering. In IDLE everything is zero, so slave
    // responses arriving after a release or reset never reach a master.
    always_comb begin
        s_adr_o  = 32'd0;
        s_dat_o  = 32'd0;
        s_sel_o  = 4'd0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_dat_o = 32'd0;
        m1_dat_o = 32'd0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i && !timeout_hit;
                s_stb_o  = m0_stb_i && !timeout_hit;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = timeout_hit;
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i && !timeout_hit;
                s_stb_o  = m1_stb_i && !timeout_hit;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = timeout_hit;
            end
            default: ;
        endcase
    end

endmodule
